// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: state encoding, chunk limit, chunk helper.
package shift_seq_pkg;

   // Largest per-pass amount, fixed by the external shifter's 3-bit amount input.
   localparam int unsigned MaxChunk = 7;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Amount handed to the shifter for one pass, given the remaining amount.
   function automatic logic [2:0] chunk_of(input logic [4:0] rem);
      return (rem > 5'(MaxChunk)) ? 3'(MaxChunk) : rem[2:0];
   endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Requester and shifter signals of the shift sequencer, bundled for port connection.
interface shift_seq_if;
   logic       req0;
   logic       req1;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [4:0] amt0;
   logic [4:0] amt1;
   logic       ack0;
   logic       ack1;
   logic [7:0] result;
   logic       busy;
   logic [7:0] sh_a;
   logic [2:0] sh_b;
   logic [7:0] sh_in;

   // Requesters plus the external shifter.
   modport master (
      output req0, req1, data0, data1, amt0, amt1, sh_in,
      input  ack0, ack1, result, busy, sh_a, sh_b
   );

   // The sequencer itself.
   modport slave (
      input  req0, req1, data0, data1, amt0, amt1, sh_in,
      output ack0, ack1, result, busy, sh_a, sh_b
   );
endinterface

// File: rtl/shift_seq_rr_arb2.sv
// Two-way round-robin arbiter (rr_arb2): one-hot grant, combinational, gated by en.
module shift_seq_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

   // On a tie the requester that was not served last wins.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/shift_seq.sv
// Sequencer and two-port arbiter for the shared 8-bit right shifter.
// Long shifts are split into passes of at most MaxChunk bits, one pass per cycle.
module shift_seq
   import shift_seq_pkg::*;
(
   input logic        clk,
   input logic        rst,
   shift_seq_if.slave bus
);

   state_e     state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic [4:0] rem_q, rem_d;
   logic       sel_q, sel_d;
   logic       last_q, last_d;
   logic [7:0] result_q;
   logic       ack0_q, ack1_q, busy_q;
   logic [1:0] gnt;
   logic [2:0] chunk;

   assign chunk = chunk_of(rem_q);

   shift_seq_rr_arb2 u_rr_arb2 (
      .req  ({bus.req1, bus.req0}),
      .last (last_q),
      .en   (state_q == StIdle),
      .gnt  (gnt)
   );

   // Next-state and datapath decode.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (gnt != 2'b00) begin
               sel_d   = gnt[1];
               acc_d   = gnt[1] ? bus.data1 : bus.data0;
               rem_d   = gnt[1] ? bus.amt1 : bus.amt0;
               state_d = StShift;
            end
         end
         StShift: begin
            acc_d = bus.sh_in;
            rem_d = rem_q - 5'(chunk);
            // No early exit on a zero accumulator: pass count depends only on the amount.
            if (rem_q <= 5'(MaxChunk)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            last_d  = sel_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; ack/result/busy are computed one cycle ahead.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         rem_q    <= '0;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         result_q <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         ack0_q   <= (state_d == StDone) && !sel_d;
         ack1_q   <= (state_d == StDone) && sel_d;
         busy_q   <= (state_d != StIdle);
         if (state_d == StDone) begin
            result_q <= acc_d;
         end
      end
   end

   assign bus.ack0   = ack0_q;
   assign bus.ack1   = ack1_q;
   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.sh_a   = acc_q;
   assign bus.sh_b   = (state_q == StShift) ? chunk : 3'd0;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed literal cases followed by randomized two-requester traffic,
// all checked each cycle against a schedule-based transaction model.
module tb_shift_seq;
   import shift_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   shift_seq_if bus ();

   shift_seq u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External shifter beside the block.
   assign bus.sh_in = bus.sh_a >> bus.sh_b;

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Transaction model: a grant at edge E puts the block in pass k (1..P) during the cycle
   // after E+k-1 and in its ack cycle at k = P+1. Everything else is arithmetic on k.
   logic       m_ok = 1'b0;
   logic       m_on = 1'b0;
   logic       m_sel = 1'b0;
   logic       m_last = 1'b1;
   int         m_k = 0;
   int         m_p = 0;
   logic [7:0] m_data = '0;
   logic [4:0] m_amt = '0;
   logic [7:0] m_res = '0;
   logic [7:0] m_hold = '0;

   wire        m_w  = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
   wire  [7:0] m_wd = m_w ? bus.data1 : bus.data0;
   wire  [4:0] m_wa = m_w ? bus.amt1 : bus.amt0;

   always @(posedge clk) begin
      if (rst) begin
         m_ok   <= 1'b1;
         m_on   <= 1'b0;
         m_last <= 1'b1;
         m_hold <= '0;
      end else if (m_on) begin
         if (m_k == m_p + 1) begin
            m_on   <= 1'b0;
            m_last <= m_sel;
         end else begin
            m_k <= m_k + 1;
            if (m_k == m_p) m_hold <= m_res;
         end
      end else if (bus.req0 || bus.req1) begin
         m_on   <= 1'b1;
         m_sel  <= m_w;
         m_data <= m_wd;
         m_amt  <= m_wa;
         m_res  <= m_wd >> m_wa;
         m_p    <= (m_wa == 5'd0) ? 1 : (int'(m_wa) + 6) / 7;
         m_k    <= 1;
      end
   end

   function automatic logic [2:0] exp_shb();
      if (!m_on || m_k > m_p) return 3'd0;
      return 3'(imin(int'(MaxChunk), int'(m_amt) - int'(MaxChunk) * (m_k - 1)));
   endfunction

   function automatic logic [7:0] exp_sha();
      if (!m_on) return m_hold;
      if (m_k > m_p) return m_res;
      return m_data >> imin(int'(m_amt), int'(MaxChunk) * (m_k - 1));
   endfunction

   logic ack0_seen = 1'b0;
   logic ack1_seen = 1'b0;

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      ack0_seen <= bus.ack0;
      ack1_seen <= bus.ack1;
      if (m_ok) begin
         check("cycle busy", 32'(bus.busy), 32'(m_on));
         check("cycle ack0", 32'(bus.ack0), 32'(m_on && m_k == m_p + 1 && !m_sel));
         check("cycle ack1", 32'(bus.ack1), 32'(m_on && m_k == m_p + 1 && m_sel));
         check("cycle result", 32'(bus.result), 32'(m_hold));
         check("cycle sh_b", 32'(bus.sh_b), 32'(exp_shb()));
         check("cycle sh_a", 32'(bus.sh_a), 32'(exp_sha()));
      end
   end

   logic [31:0] shb_hist;
   logic [7:0]  busy_hist;

   // Waits for any ack; cyc counts negedges from 0 (the request cycle), -1 on timeout.
   task automatic wait_ack(output int cyc, output logic a0, output logic a1, input bit scr);
      cyc = -1;
      a0  = 1'b0;
      a1  = 1'b0;
      shb_hist  = '0;
      busy_hist = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         shb_hist  = {shb_hist[27:0], 1'b0, bus.sh_b};
         busy_hist = {busy_hist[6:0], bus.busy};
         if (bus.ack0 || bus.ack1) begin
            cyc = i;
            a0  = bus.ack0;
            a1  = bus.ack1;
            return;
         end
         // Operands are only meaningful at grant; scramble them afterwards.
         if (scr && i >= 1) begin
            bus.data0 = 8'($urandom);
            bus.data1 = 8'($urandom);
            bus.amt0  = 5'($urandom);
            bus.amt1  = 5'($urandom);
         end
      end
   endtask

   task automatic run_txn(input string nm, input bit port, input logic [7:0] d,
                          input logic [4:0] a, input logic [7:0] exp_res, input int exp_cyc);
      int   cyc;
      logic a0, a1;
      @(posedge clk);
      #1;
      if (port) begin
         bus.req1 = 1'b1; bus.data1 = d; bus.amt1 = a;
      end else begin
         bus.req0 = 1'b1; bus.data0 = d; bus.amt0 = a;
      end
      wait_ack(cyc, a0, a1, 1'b1);
      check({nm, " ack cycle"}, 32'(cyc), 32'(exp_cyc));
      check({nm, " ack0"}, 32'(a0), 32'(!port));
      check({nm, " ack1"}, 32'(a1), 32'(port));
      check({nm, " result"}, 32'(bus.result), 32'(exp_res));
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   initial begin
      int   cyc;
      logic a0, a1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.data0 = '0; bus.data1 = '0; bus.amt0 = '0; bus.amt1 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Tie after reset: req0 first, then req1 one IDLE cycle later.
      @(posedge clk);
      #1;
      bus.req0 = 1'b1; bus.data0 = 8'h81; bus.amt0 = 5'd1;
      bus.req1 = 1'b1; bus.data1 = 8'h42; bus.amt1 = 5'd1;
      wait_ack(cyc, a0, a1, 1'b0);
      check("tie1 ack0", 32'(a0), 32'd1);
      check("tie1 ack1", 32'(a1), 32'd0);
      check("tie1 cycle", 32'(cyc), 32'd2);
      check("tie1 result", 32'(bus.result), 32'h40);
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      wait_ack(cyc, a0, a1, 1'b0);
      check("held req1 ack1", 32'(a1), 32'd1);
      check("held req1 cycle", 32'(cyc), 32'd2);
      check("held req1 result", 32'(bus.result), 32'h21);
      @(posedge clk);
      #1;
      bus.req1 = 1'b0;

      // Re-raised tie: req1 was served last, so req0 wins again.
      @(posedge clk);
      #1;
      bus.req0 = 1'b1; bus.data0 = 8'hF0; bus.amt0 = 5'd4;
      bus.req1 = 1'b1; bus.data1 = 8'h0F; bus.amt1 = 5'd1;
      wait_ack(cyc, a0, a1, 1'b0);
      check("tie2 ack0", 32'(a0), 32'd1);
      check("tie2 result", 32'(bus.result), 32'h0F);
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;
      wait_ack(cyc, a0, a1, 1'b0);
      check("tie2b ack1", 32'(a1), 32'd1);
      check("tie2b result", 32'(bus.result), 32'h07);
      @(posedge clk);
      #1;
      bus.req1 = 1'b0;

      run_txn("amt0", 1'b0, 8'h2B, 5'd0, 8'h2B, 2);
      check("amt0 sh_b seq", shb_hist[7:0], 32'h00);
      run_txn("amt3", 1'b0, 8'h2B, 5'd3, 8'h05, 2);
      check("amt3 sh_b seq", shb_hist[7:0], 32'h30);
      run_txn("amt7", 1'b1, 8'hFF, 5'd7, 8'h01, 2);
      run_txn("amt8", 1'b0, 8'hFF, 5'd8, 8'h00, 3);
      check("amt8 sh_b seq", shb_hist[11:0], 32'h710);
      run_txn("amt10", 1'b1, 8'hFF, 5'd10, 8'h00, 3);
      check("amt10 sh_b seq", shb_hist[11:0], 32'h730);
      run_txn("amt29", 1'b1, 8'hFF, 5'd29, 8'h00, 6);
      run_txn("amt31", 1'b0, 8'h80, 5'd31, 8'h00, 6);
      check("amt31 sh_b seq", shb_hist[23:0], 32'h777730);
      check("amt31 busy", 32'(busy_hist[6:0]), 32'b0111111);
      run_txn("amt2", 1'b0, 8'hB4, 5'd2, 8'h2D, 2);

      // Reset during the third pass of an amt 31 shift.
      @(posedge clk);
      #1;
      bus.req0 = 1'b1; bus.data0 = 8'hFF; bus.amt0 = 5'd31;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst result", 32'(bus.result), 32'd0);
      check("rst ack0", 32'(bus.ack0), 32'd0);
      wait_ack(cyc, a0, a1, 1'b0);
      check("rst regrant ack0", 32'(a0), 32'd1);
      check("rst regrant cycle", 32'(cyc), 32'd5);
      @(posedge clk);
      #1;
      bus.req0 = 1'b0;

      // Random traffic: requesters hold until acked, operands churn every cycle.
      repeat (3000) begin
         @(posedge clk);
         #1;
         if (ack0_seen) bus.req0 = 1'b0;
         else if (!bus.req0 && $urandom_range(0, 3) == 0) bus.req0 = 1'b1;
         if (ack1_seen) bus.req1 = 1'b0;
         else if (!bus.req1 && $urandom_range(0, 3) == 0) bus.req1 = 1'b1;
         bus.data0 = 8'($urandom);
         bus.data1 = 8'($urandom);
         bus.amt0  = 5'($urandom_range(0, 31));
         bus.amt1  = 5'($urandom_range(0, 31));
         rst = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
